vga_scaled_framebuffer: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing_gen.sv | 71 +++++++
 rtl/vga_scaled_framebuffer.sv | 180 ++++++++++++++++++
 tb/tb_vga_scaled_framebuffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, total-period helpers
// and the {B,G,R} pixel packing order.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Channel slot within a packed pixel, counted in COLOR_BITS units.
    localparam int PIX_R = 0;
    localparam int PIX_G = 1;
    localparam int PIX_B = 2;

    function automatic int h_total(
        input int vis,
        input int fp,
        input int sync,
        input int bp
    );
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(
        input int vis,
        input int fp,
        input int sync,
        input int bp
    );
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters with sync, visible, vblank and frame_start decode.
// Ports: clk/rst in; h, v, line_end, frame_end, visible, vblank,
// hsync_n, vsync_n, frame_start out (all in the counter domain).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          line_end,
    output logic          frame_end,
    output logic          visible,
    output logic          vblank,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          frame_start
);

    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        line_end  = (32'(h_q) == H_TOTAL - 1);
        frame_end = line_end && (32'(v_q) == V_TOTAL - 1);
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (line_end) begin
            h_d = '0;
            v_d = frame_end ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h       = h_q;
    assign v       = v_q;
    assign visible = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
    assign vblank  = (32'(v_q) >= V_VISIBLE);
    assign hsync_n = !((32'(h_q) >= HS_START) && (32'(h_q) < HS_END));
    assign vsync_n = !((32'(v_q) >= VS_START) && (32'(v_q) < VS_END));
    // Counters sit at 0,0 during reset; the pulse must not fire there.
    assign frame_start = !rst && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scaled_framebuffer.sv
// VGA scan-out of a double-buffered, pixel-replicated framebuffer.
// Ports: clk/rst; we/write_addr/write_data back-buffer writes; swap_req
// in, swap_done out; vblank, frame_start, vga_r/g/b, vga_hsync/vsync out.
module vga_scaled_framebuffer
    import vga_pkg::*;
#(
    parameter int H_VISIBLE     = DEF_H_VISIBLE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_VISIBLE     = DEF_V_VISIBLE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter int COLOR_BITS    = 1,
    parameter int SCALE_SHIFT   = 1,
    parameter int DOUBLE_BUFFER = 1,
    localparam int FB_W     = H_VISIBLE >> SCALE_SHIFT,
    localparam int FB_H     = V_VISIBLE >> SCALE_SHIFT,
    localparam int FB_DEPTH = FB_W * FB_H,
    localparam int ADDR_W   = $clog2(FB_DEPTH),
    localparam int PIX_W    = 3 * COLOR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [PIX_W-1:0]      write_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  vblank,
    output logic                  frame_start,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int NBUF = (DOUBLE_BUFFER != 0) ? 2 : 1;
    localparam int MEM_DEPTH = FB_DEPTH * NBUF;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int SMASK = (1 << SCALE_SHIFT) - 1;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic line_end, frame_end, visible, hsync_n, vsync_n;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h           (h),
        .v           (v),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .visible     (visible),
        .vblank      (vblank),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_start (frame_start)
    );

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic              wr_en;

    logic front_sel_q, front_sel_d;
    logic swap_pending_q, swap_pending_d;
    logic swap_done_q, swap_done_d;
    logic swap_take;

    logic [PIX_W-1:0] mem_q [MEM_DEPTH];
    logic [PIX_W-1:0] rd_data_q, rd_data_d;
    logic vis_s1_q, hs_s1_q, vs_s1_q;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic hs_q, vs_q;

    // Row base and column stop at the last block instead of running one
    // step past it, so their sum always stays below FB_DEPTH.
    always_comb begin
        col_d      = col_q;
        row_base_d = row_base_q;
        if (frame_end) begin
            col_d      = '0;
            row_base_d = '0;
        end else if (line_end) begin
            col_d = '0;
            if (((32'(v) & SMASK) == SMASK) && (32'(v) < V_VISIBLE - 1)) begin
                row_base_d = row_base_q + ADDR_W'(FB_W);
            end
        end else if (visible && ((32'(h) & SMASK) == SMASK)
                     && (32'(h) < H_VISIBLE - 1)) begin
            col_d = col_q + ADDR_W'(1);
        end
    end

    always_comb begin
        rd_addr = row_base_q + col_q;
        rd_idx  = MEM_AW'(rd_addr);
        wr_idx  = MEM_AW'(write_addr);
        if (DOUBLE_BUFFER != 0) begin
            if (front_sel_q) begin
                rd_idx = rd_idx + MEM_AW'(FB_DEPTH);
            end else begin
                wr_idx = wr_idx + MEM_AW'(FB_DEPTH);
            end
        end
        wr_en     = we && (32'(write_addr) < FB_DEPTH);
        rd_data_d = mem_q[rd_idx];
    end

    always_comb begin
        swap_take = line_end && (32'(v) == V_VISIBLE - 1)
                    && (swap_pending_q || swap_req);
        swap_pending_d = swap_take ? 1'b0 : (swap_pending_q || swap_req);
        front_sel_d    = front_sel_q ^ (swap_take && (DOUBLE_BUFFER != 0));
        swap_done_d    = swap_take;
        rgb_d          = vis_s1_q ? rd_data_q : '0;
    end

    // Storage has no reset; read-before-write falls out of the NBA order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            row_base_q     <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_data_q      <= '0;
            vis_s1_q       <= 1'b0;
            hs_s1_q        <= 1'b1;
            vs_s1_q        <= 1'b1;
            rgb_q          <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
        end else begin
            col_q          <= col_d;
            row_base_q     <= row_base_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            rd_data_q      <= rd_data_d;
            vis_s1_q       <= visible;
            hs_s1_q        <= hsync_n;
            vs_s1_q        <= vsync_n;
            rgb_q          <= rgb_d;
            hs_q           <= hs_s1_q;
            vs_q           <= vs_s1_q;
        end
    end

    assign swap_done = swap_done_q;
    assign vga_r     = rgb_q[PIX_R*COLOR_BITS +: COLOR_BITS];
    assign vga_g     = rgb_q[PIX_G*COLOR_BITS +: COLOR_BITS];
    assign vga_b     = rgb_q[PIX_B*COLOR_BITS +: COLOR_BITS];
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;

endmodule

// File: tb/tb_vga_scaled_framebuffer.sv
// Bench for vga_scaled_framebuffer on a reduced raster, double- and
// single-buffer instances side by side against a frame-level model.
module tb_vga_scaled_framebuffer;

    localparam int HV = 12, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FBW = HV / 2;
    localparam int DEPTH = FBW * (VV / 2);

    logic clk = 1'b0;
    logic rst, we, swap_req;
    logic [4:0] write_addr;
    logic [2:0] write_data;

    logic done_a, vb_a, fs_a, r_a, g_a, b_a, hs_a, vs_a;
    logic done_b, vb_b, fs_b, r_b, g_b, b_b, hs_b, vs_b;

    always #5 clk = ~clk;

    vga_scaled_framebuffer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COLOR_BITS(1), .SCALE_SHIFT(1), .DOUBLE_BUFFER(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr),
        .write_data(write_data), .swap_req(swap_req),
        .swap_done(done_a), .vblank(vb_a), .frame_start(fs_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a)
    );

    vga_scaled_framebuffer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COLOR_BITS(1), .SCALE_SHIFT(1), .DOUBLE_BUFFER(0)
    ) dut_sb (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr),
        .write_data(write_data), .swap_req(swap_req),
        .swap_done(done_b), .vblank(vb_b), .frame_start(fs_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b)
    );

    wire [2:0] rgb_a = {b_a, g_a, r_a};
    wire [2:0] rgb_b = {b_b, g_b, r_b};

    // Frame-level model: raster position is cycles since reset.
    int t = 0;
    int front = 0;
    bit pend = 0;
    bit m_done = 0;
    logic [2:0] fb_db [2][DEPTH];
    logic [2:0] fb_sb [DEPTH];
    logic [2:0] p1_a = 0, p2_a = 0, p1_b = 0, p2_b = 0;
    logic p1_hs = 1, p2_hs = 1, p1_vs = 1, p2_vs = 1;

    always @(posedge clk) begin
        int h, v, idx;
        bit vis, take;
        if (rst) begin
            t = 0; front = 0; pend = 0; m_done = 0;
            p1_a = 0; p2_a = 0; p1_b = 0; p2_b = 0;
            p1_hs = 1; p2_hs = 1; p1_vs = 1; p2_vs = 1;
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            vis = (h < HV) && (v < VV);
            idx = (v / 2) * FBW + (h / 2);
            p2_a = p1_a;
            p1_a = vis ? fb_db[front][idx] : 3'b0;
            p2_b = p1_b;
            p1_b = vis ? fb_sb[idx] : 3'b0;
            p2_hs = p1_hs;
            p1_hs = !(h >= HV + HF && h < HV + HF + HS);
            p2_vs = p1_vs;
            p1_vs = !(v >= VV + VF && v < VV + VF + VS);
            if (we && write_addr < DEPTH) begin
                fb_db[1 - front][write_addr] = write_data;
                fb_sb[write_addr] = write_data;
            end
            take = (h == HT - 1) && (v == VV - 1) && (pend || swap_req);
            m_done = take;
            if (take) begin
                pend = 0;
                front = 1 - front;
            end else if (swap_req) begin
                pend = 1;
            end
            t = t + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)",
                     name, got, exp, t);
        end
    endtask

    task automatic cyc();
        logic [15:0] got, exp;
        bit vbe, fse;
        @(negedge clk);
        if (chk_en) begin
            vbe = ((t / HT) % VT) >= VV;
            fse = !rst && (t % FT == 0);
            got = {rgb_a, rgb_b, hs_a, vs_a, hs_b, vs_b,
                   done_a, done_b, vb_a, fs_a, vb_b, fs_b};
            exp = {p2_a, p2_b, p2_hs, p2_vs, p2_hs, p2_vs,
                   m_done, m_done, vbe, fse, vbe, fse};
            check("cycle", 32'(got), 32'(exp));
        end
    endtask

    task automatic wr(input int a, input logic [2:0] d);
        we = 1; write_addr = 5'(a); write_data = d;
        cyc();
        we = 0;
    endtask

    task automatic pulse_swap();
        swap_req = 1;
        cyc();
        swap_req = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_a && n < 2 * FT) begin
            cyc();
            n++;
        end
        check(name, 32'(done_a), 1);
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        while ((t % FT) != pos && n < 2 * FT) begin
            cyc();
            n++;
        end
    endtask

    // Wait until the outputs show screen pixel (x,y).
    task automatic wait_pixel(input int x, input int y);
        int n = 0;
        while (((t + FT - 2) % FT) != y * HT + x && n < 2 * FT) begin
            cyc();
            n++;
        end
    endtask

    typedef struct {
        bit         wr;
        int         addr;
        logic [2:0] data;
        int         px;
        int         py;
        logic [2:0] exp;
    } vec_t;

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[15];
        int k, n, m;
        tbl[0]  = '{1, 0, 3'b001, 0, 0, 3'b000};
        tbl[1]  = '{1, 1, 3'b100, 0, 0, 3'b000};
        tbl[2]  = '{1, 23, 3'b010, 0, 0, 3'b000};
        tbl[3]  = '{1, 24, 3'b111, 0, 0, 3'b000};
        tbl[4]  = '{0, 0, 3'b000, 0, 0, 3'b001};
        tbl[5]  = '{0, 0, 3'b000, 1, 0, 3'b001};
        tbl[6]  = '{0, 0, 3'b000, 0, 1, 3'b001};
        tbl[7]  = '{0, 0, 3'b000, 1, 1, 3'b001};
        tbl[8]  = '{0, 0, 3'b000, 2, 0, 3'b100};
        tbl[9]  = '{0, 0, 3'b000, 3, 0, 3'b100};
        tbl[10] = '{0, 0, 3'b000, 3, 1, 3'b100};
        tbl[11] = '{0, 0, 3'b000, 10, 6, 3'b010};
        tbl[12] = '{0, 0, 3'b000, 11, 6, 3'b010};
        tbl[13] = '{0, 0, 3'b000, 10, 7, 3'b010};
        tbl[14] = '{0, 0, 3'b000, 11, 7, 3'b010};

        rst = 1; we = 0; swap_req = 0; write_addr = 0; write_data = 0;
        repeat (3) cyc();
        check("rst_rgb", 32'({rgb_a, rgb_b}), 0);
        check("rst_sync", 32'({hs_a, vs_a, hs_b, vs_b}), 32'hf);
        check("rst_pulse", 32'({done_a, done_b, fs_a, fs_b}), 0);
        rst = 0;

        k = 0;
        while (hs_a && k < 200) begin cyc(); k++; end
        check("hsync_first", k, HV + HF + 2);
        n = 0;
        while (!hs_a && n < 200) begin cyc(); n++; end
        check("hsync_width", n, HS);
        k = 0;
        while (vs_a && k < 2 * FT) begin cyc(); k++; end
        n = 0;
        while (!vs_a && n < 2 * FT) begin cyc(); n++; end
        check("vsync_width", n, VS * HT);
        k = 0;
        while (!fs_a && k < 2 * FT) begin cyc(); k++; end
        n = 0;
        do begin cyc(); n++; end while (!fs_a && n < 2 * FT);
        check("frame_period", n, FT);

        for (int a = 0; a < DEPTH; a++) wr(a, 3'($urandom));
        pulse_swap();
        wait_done("init_swap1");
        for (int a = 0; a < DEPTH; a++) wr(a, 3'($urandom));
        pulse_swap();
        wait_done("init_swap2");
        chk_en = 1;

        foreach (tbl[i]) if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
        pulse_swap();
        wait_done("tbl_swap");
        foreach (tbl[i]) begin
            if (!tbl[i].wr) begin
                wait_pixel(tbl[i].px, tbl[i].py);
                check($sformatf("pix_db_%0d_%0d", tbl[i].px, tbl[i].py),
                      32'(rgb_a), 32'(tbl[i].exp));
                check($sformatf("pix_sb_%0d_%0d", tbl[i].px, tbl[i].py),
                      32'(rgb_b), 32'(tbl[i].exp));
            end
        end

        wait_pos(3 * HT);
        pulse_swap();
        n = 0;
        while (!done_a && n < 2 * FT) begin cyc(); n++; end
        check("swap_done_pos", t % FT, VV * HT);

        wait_pos(VV * HT - 1);
        swap_req = 1;
        cyc();
        swap_req = 0;
        check("swap_at_point", 32'(done_a), 1);

        wait_pos(HT);
        pulse_swap();
        wait_pos(4 * HT);
        pulse_swap();
        m = 0;
        repeat (FT) begin cyc(); if (done_a) m++; end
        check("two_req_one_swap", m, 1);

        for (int a = 0; a < DEPTH; a++) wr(a, 3'($urandom));
        m = 0;
        repeat (3 * FT) begin cyc(); if (done_a) m++; end
        check("noswap_no_done", m, 0);
        wait_pixel(4, 2);
        check("noswap_pix", 32'(rgb_a), 32'(fb_db[front][FBW + 2]));

        repeat (6 * FT) begin
            we = 1'($urandom_range(0, 1));
            write_addr = 5'($urandom_range(0, 31));
            write_data = 3'($urandom);
            swap_req = ($urandom_range(0, 99) == 0);
            cyc();
        end
        we = 0; swap_req = 0;

        wait_pos(HT);
        pulse_swap();
        wait_pos(5 * HT);
        rst = 1;
        cyc();
        check("midrst_rgb", 32'({rgb_a, rgb_b}), 0);
        check("midrst_sync", 32'({hs_a, vs_a, hs_b, vs_b}), 32'hf);
        check("midrst_done", 32'({done_a, done_b}), 0);
        rst = 0;
        #1;
        check("midrst_fs", 32'(fs_a), 1);
        n = 0; m = 0;
        do begin
            cyc(); n++;
            if (done_a) m++;
        end while (!fs_a && n < 2 * FT);
        check("midrst_period", n, FT);
        check("midrst_pend_drop", m, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
